// File: rtl/ibex_pext_mult_seq.sv
// rtl/ibex_pext_mult_seq.sv - sequencer sharing a 32x16 P-ext multiplier array across one/two-pass ops
// Latches an operation, drives the array for one or two passes and returns a 64-bit result.
module ibex_pext_mult_seq #(
  parameter int unsigned MulLatency = 0
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        valid_i,
  output logic        ready_o,
  input  logic [1:0]  op_i,
  input  logic [31:0] op_a_i,
  input  logic [31:0] op_b_i,
  input  logic [31:0] acc_i,
  input  logic        signed_a_i,
  input  logic        signed_b_i,
  input  logic        flush_i,
  output logic        mul_valid_o,
  output logic [31:0] mul_a_o,
  output logic        mul_a_signed_o,
  output logic [15:0] mul_b_o,
  output logic        mul_b_signed_o,
  input  logic [47:0] mul_result_i,
  output logic        valid_o,
  input  logic        ready_i,
  output logic [63:0] result_o,
  output logic        busy_o
);

  typedef enum logic [1:0] {S_IDLE, S_PASS0, S_PASS1, S_DONE} state_e;

  localparam logic [1:0] OP_SINGLE   = 2'b00;
  localparam logic [1:0] OP_FULL     = 2'b01;
  localparam logic [1:0] OP_HIGH_RND = 2'b10;
  localparam logic [1:0] OP_MAC      = 2'b11;
  localparam logic [1:0] LP_LAT      = 2'(MulLatency);

  state_e      r_state, w_state_nxt;
  logic [1:0]  r_cnt, w_cnt_nxt;
  logic [63:0] r_accum, w_accum_nxt;
  logic [31:0] r_a, r_b, r_acc;
  logic [1:0]  r_op;
  logic        r_sa, r_sb;

  logic        w_two_pass, w_in_pass, w_last, w_accept, w_any_signed, w_prod_signed;
  logic [63:0] w_prod_ext, w_acc_ext, w_sum, w_hi;
  logic [31:0] w_rnd_hi;

  assign w_two_pass   = (r_op == OP_FULL) || (r_op == OP_HIGH_RND);
  assign w_in_pass    = (r_state == S_PASS0) || (r_state == S_PASS1);
  assign w_last       = w_in_pass && (r_cnt == LP_LAT);
  assign w_accept     = valid_i && ready_o;
  assign w_any_signed = r_sa | r_sb;

  assign ready_o  = (r_state == S_IDLE);
  assign busy_o   = (r_state != S_IDLE);
  assign valid_o  = (r_state == S_DONE);
  assign result_o = r_accum;

  // Low half of a two-pass multiplier is always unsigned; its sign lives in the high half.
  assign mul_valid_o    = w_in_pass && (r_cnt == 2'd0);
  assign mul_a_o        = r_a;
  assign mul_a_signed_o = w_in_pass & r_sa;
  assign mul_b_o        = (r_state == S_PASS1) ? r_b[31:16] : r_b[15:0];
  assign mul_b_signed_o = ((r_state == S_PASS1) || ((r_state == S_PASS0) && !w_two_pass)) & r_sb;

  assign w_prod_signed = mul_a_signed_o | mul_b_signed_o;
  assign w_prod_ext    = w_prod_signed ? {{16{mul_result_i[47]}}, mul_result_i}
                                       : {16'd0, mul_result_i};
  assign w_acc_ext     = w_any_signed ? {{32{r_acc[31]}}, r_acc} : {32'd0, r_acc};
  assign w_sum         = r_accum + (w_prod_ext << 16);
  // Adding 2^31 then taking bits [63:32] equals the upper word plus the carry out of bit 31.
  assign w_rnd_hi      = w_sum[63:32] + {31'd0, w_sum[31]};
  assign w_hi          = {{32{w_rnd_hi[31] & w_any_signed}}, w_rnd_hi};

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_accum_nxt = r_accum;
    if (flush_i && (r_state != S_IDLE)) begin
      w_state_nxt = S_IDLE;
      w_cnt_nxt   = 2'd0;
      w_accum_nxt = 64'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (valid_i) begin
            w_state_nxt = S_PASS0;
            w_cnt_nxt   = 2'd0;
          end
        end
        S_PASS0: begin
          if (w_last) begin
            w_cnt_nxt = 2'd0;
            if (w_two_pass) begin
              w_state_nxt = S_PASS1;
              w_accum_nxt = w_prod_ext;
            end else begin
              w_state_nxt = S_DONE;
              w_accum_nxt = (r_op == OP_MAC) ? (w_prod_ext + w_acc_ext) : w_prod_ext;
            end
          end else begin
            w_cnt_nxt = r_cnt + 2'd1;
          end
        end
        S_PASS1: begin
          if (w_last) begin
            w_cnt_nxt   = 2'd0;
            w_state_nxt = S_DONE;
            w_accum_nxt = (r_op == OP_HIGH_RND) ? w_hi : w_sum;
          end else begin
            w_cnt_nxt = r_cnt + 2'd1;
          end
        end
        S_DONE: begin
          if (ready_i) begin
            w_state_nxt = S_IDLE;
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= S_IDLE;
      r_cnt   <= 2'd0;
      r_accum <= 64'd0;
      r_a     <= 32'd0;
      r_b     <= 32'd0;
      r_acc   <= 32'd0;
      r_op    <= OP_SINGLE;
      r_sa    <= 1'b0;
      r_sb    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_accum <= w_accum_nxt;
      if (w_accept) begin
        r_a   <= op_a_i;
        r_b   <= op_b_i;
        r_acc <= acc_i;
        r_op  <= op_i;
        r_sa  <= signed_a_i;
        r_sb  <= signed_b_i;
      end
    end
  end

endmodule

// File: tb/tb_ibex_pext_mult_seq.sv
// tb/tb_ibex_pext_mult_seq.sv - bench for ibex_pext_mult_seq at array latencies 0, 1 and 2
`timescale 1ns/1ps
module tb_ibex_pext_mult_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [2:0]  valid_i, sa_i, sb_i, flush_i, ready_i;
  logic [1:0]  op_i  [3];
  logic [31:0] a_i   [3];
  logic [31:0] b_i   [3];
  logic [31:0] acc_i [3];
  wire  [2:0]  ready_o, mul_valid_o, mul_as_o, mul_bs_o, valid_o, busy_o;
  wire  [31:0] mul_a_o  [3];
  wire  [15:0] mul_b_o  [3];
  wire  [47:0] mul_res  [3];
  wire  [63:0] result_o [3];

  int total = 0;
  int bad   = 0;

  // DUT g runs with array latency g; each gets its own array model that emits junk off-cycle.
  for (genvar g = 0; g < 3; g++) begin : g_dut
    logic signed [49:0] w_p;
    logic [47:0] r_pipe [3];
    logic [47:0] r_junk;

    always_comb w_p = $signed({mul_as_o[g] & mul_a_o[g][31], mul_a_o[g]}) *
                      $signed({mul_bs_o[g] & mul_b_o[g][15], mul_b_o[g]});

    always @(posedge clk) begin
      r_junk    <= 48'({$urandom(), $urandom()});
      r_pipe[0] <= mul_valid_o[g] ? w_p[47:0] : r_junk;
      r_pipe[1] <= r_pipe[0];
      r_pipe[2] <= r_pipe[1];
    end

    if (g == 0) begin : g_comb
      assign mul_res[g] = mul_valid_o[g] ? w_p[47:0] : r_junk;
    end else begin : g_seq
      assign mul_res[g] = r_pipe[g-1];
    end

    ibex_pext_mult_seq #(.MulLatency(g)) u_dut (
      .clk_i(clk), .rst_ni(rst_n), .valid_i(valid_i[g]), .ready_o(ready_o[g]),
      .op_i(op_i[g]), .op_a_i(a_i[g]), .op_b_i(b_i[g]), .acc_i(acc_i[g]),
      .signed_a_i(sa_i[g]), .signed_b_i(sb_i[g]), .flush_i(flush_i[g]),
      .mul_valid_o(mul_valid_o[g]), .mul_a_o(mul_a_o[g]), .mul_a_signed_o(mul_as_o[g]),
      .mul_b_o(mul_b_o[g]), .mul_b_signed_o(mul_bs_o[g]), .mul_result_i(mul_res[g]),
      .valid_o(valid_o[g]), .ready_i(ready_i[g]), .result_o(result_o[g]), .busy_o(busy_o[g])
    );
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Whole-operand arithmetic: a 32x16 or 32x32 product with the requested signedness.
  function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                        input logic [31:0] acc, input logic sa, input logic sb);
    logic [63:0] ea, eb, eacc, p, t, r, res;
    logic s;
    s    = sa | sb;
    ea   = sa ? {{32{a[31]}}, a} : {32'd0, a};
    eacc = s ? {{32{acc[31]}}, acc} : {32'd0, acc};
    if (op == 2'b00 || op == 2'b11) eb = sb ? {{48{b[15]}}, b[15:0]} : {48'd0, b[15:0]};
    else                            eb = sb ? {{32{b[31]}}, b} : {32'd0, b};
    p = ea * eb;
    case (op)
      2'b11:   res = p + eacc;
      2'b10: begin
        t   = p + 64'h8000_0000;
        r   = s ? 64'($signed(t) >>> 32) : (t >> 32);
        res = s ? {{32{r[31]}}, r[31:0]} : {32'd0, r[31:0]};
      end
      default: res = p;
    endcase
    return res;
  endfunction

  function automatic logic [31:0] rnd32();
    case ($urandom_range(0, 4))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      default: return $urandom();
    endcase
  endfunction

  task automatic check_reset(input int d, input string tag);
    check_eq({tag, "_ctl"}, {58'd0, ready_o[d], valid_o[d], busy_o[d], mul_valid_o[d], mul_as_o[d], mul_bs_o[d]},
             64'b100000);
    check_eq({tag, "_res"}, result_o[d], 64'd0);
    check_eq({tag, "_ops"}, {16'd0, mul_a_o[d], mul_b_o[d]}, 64'd0);
  endtask

  task automatic scramble(input int d);
    op_i[d] = 2'($urandom()); a_i[d] = $urandom(); b_i[d] = $urandom(); acc_i[d] = $urandom();
    sa_i[d] = 1'($urandom()); sb_i[d] = 1'($urandom());
  endtask

  task automatic issue(input int d, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] acc, input logic sa, input logic sb);
    int n;
    @(posedge clk); #1;
    n = 0;
    while (!ready_o[d] && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check_eq("ready_before_issue", {63'd0, ready_o[d]}, 64'd1);
    op_i[d] = op; a_i[d] = a; b_i[d] = b; acc_i[d] = acc; sa_i[d] = sa; sb_i[d] = sb;
    valid_i[d] = 1'b1;
    @(posedge clk); #1;
    valid_i[d] = 1'b0;
    scramble(d);
  endtask

  task automatic run_op(input int d, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] acc, input logic sa, input logic sb, input int hold,
                        output logic [63:0] res);
    int lat, strobes, exp_lat, exp_n;
    logic [63:0] exp;
    exp     = model(op, a, b, acc, sa, sb);
    exp_n   = (op == 2'b01 || op == 2'b10) ? 2 : 1;
    exp_lat = (exp_n == 2) ? 3 + 2 * d : 2 + d;
    ready_i[d] = 1'b0;
    issue(d, op, a, b, acc, sa, sb);
    lat = 0;
    strobes = 0;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      if (mul_valid_o[d]) begin
        strobes++;
        check_eq("mul_a_latched", {32'd0, mul_a_o[d]}, {32'd0, a});
      end
      if (valid_o[d]) begin
        lat = c;
        break;
      end
    end
    check_eq("latency", 64'(lat), 64'(exp_lat));
    check_eq("strobes", 64'(strobes), 64'(exp_n));
    res = result_o[d];
    check_eq("result", res, exp);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      valid_i[d] = ~valid_i[d];
      scramble(d);
      @(negedge clk);
      check_eq("bp_ctl", {61'd0, valid_o[d], ready_o[d], busy_o[d]}, 64'b101);
      check_eq("bp_result", result_o[d], res);
    end
    @(posedge clk); #1;
    valid_i[d] = 1'b0;
    ready_i[d] = 1'b1;
    @(posedge clk); #1;
    ready_i[d] = 1'b0;
    @(negedge clk);
    check_eq("idle_after", {61'd0, ready_o[d], busy_o[d], valid_o[d]}, 64'b100);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] res;
    int seen;
    rst_n = 1'b0; valid_i = '0; ready_i = '0; flush_i = '0; sa_i = '0; sb_i = '0;
    for (int d = 0; d < 3; d++) begin
      op_i[d] = 2'd0; a_i[d] = 32'd0; b_i[d] = 32'd0; acc_i[d] = 32'd0;
    end
    #1;
    for (int d = 0; d < 3; d++) check_reset(d, "reset");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    run_op(0, 2'b00, 32'hFFFF_FFFE, 32'h0000_0003, 32'd0, 1'b1, 1'b1, 0, res);
    check_eq("tp_single", res, 64'hFFFF_FFFF_FFFF_FFFA);
    run_op(2, 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 1'b0, 1'b0, 0, res);
    check_eq("tp_full_u", res, 64'hFFFF_FFFE_0000_0001);
    run_op(2, 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 1'b1, 1'b1, 0, res);
    check_eq("tp_full_s", res, 64'h0000_0000_0000_0001);
    run_op(1, 2'b10, 32'h4000_0000, 32'h0000_0003, 32'd0, 1'b1, 1'b1, 0, res);
    check_eq("tp_high_rnd", res, 64'h0000_0000_0000_0001);
    run_op(1, 2'b11, 32'h0001_0000, 32'h0000_0002, 32'hFFFF_FFFF, 1'b1, 1'b1, 0, res);
    check_eq("tp_mac", res, 64'h0000_0000_0001_FFFF);

    run_op(1, 2'b01, $urandom(), $urandom(), 32'd0, 1'b1, 1'b0, 5, res);

    for (int d = 0; d < 3; d++) begin
      for (int i = 0; i < 40; i++) begin
        run_op(d, 2'($urandom()), rnd32(), rnd32(), rnd32(), 1'($urandom()), 1'($urandom()),
               $urandom_range(0, 3), res);
      end
    end

    // Flush while the second pass of a FULL op is in progress (latency 2).
    issue(2, 2'b01, $urandom(), $urandom(), 32'd0, 1'b1, 1'b1);
    repeat (4) @(posedge clk);
    #1;
    check_eq("pre_flush_busy", {63'd0, busy_o[2]}, 64'd1);
    flush_i[2] = 1'b1;
    @(posedge clk); #1;
    flush_i[2] = 1'b0;
    @(negedge clk);
    check_eq("flush_idle", {61'd0, ready_o[2], busy_o[2], valid_o[2]}, 64'b100);
    seen = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (valid_o[2]) seen++;
    end
    check_eq("flush_no_valid", 64'(seen), 64'd0);
    run_op(2, 2'b10, rnd32(), rnd32(), 32'd0, 1'b1, 1'b0, 0, res);

    // Asynchronous reset right after acceptance, while the first strobe is out.
    issue(2, 2'b01, $urandom() | 32'h1, $urandom(), 32'd0, 1'b1, 1'b1);
    check_eq("pre_rst_busy", {63'd0, busy_o[2]}, 64'd1);
    #1 rst_n = 1'b0;
    #1;
    check_reset(2, "mid_reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    run_op(2, 2'b01, rnd32(), rnd32(), 32'd0, 1'b0, 1'b1, 0, res);
    run_op(0, 2'b11, rnd32(), rnd32(), rnd32(), 1'b0, 1'b0, 0, res);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ibex_pext_mult_seq.md
# ibex_pext_mult_seq

Multi-cycle sequencer that shares one 32x16 P-extension multiplier array between single-pass and two-pass multiply operations. Accepts an operation from the P-ext ALU decode stage and drives the array for one or two passes. Accumulates the partial products in a 64-bit register and returns the result through a valid/ready handshake. Sits between the P-ext operand/decode logic and the 32x16 multiplier array.

## Interface
- MulLatency, 0, cycles from operand issue to valid `mul_result_i`; legal values 0, 1, 2. 0 means the array is combinational.
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous reset, active low
- valid_i  in  1  operation request
- ready_o  out  1  sequencer can accept; equals state==IDLE
- op_i  in  2  operation select
  - 00 SINGLE
  - 01 FULL
  - 10 HIGH_RND
  - 11 MAC
- op_a_i  in  32  multiplicand
- op_b_i  in  32  multiplier; SINGLE and MAC use [15:0] only
- acc_i  in  32  MAC addend
- signed_a_i  in  1  op_a is signed
- signed_b_i  in  1  op_b is signed
- flush_i  in  1  synchronous abort
- mul_valid_o  out  1  one-cycle issue strobe to the array
- mul_a_o  out  32  array operand A
- mul_a_signed_o  out  1  operand A signedness
- mul_b_o  out  16  array operand B
- mul_b_signed_o  out  1  operand B signedness
- mul_result_i  in  48  array product; signed if mul_a_signed_o or mul_b_signed_o, else unsigned
- valid_o  out  1  result valid
- ready_i  in  1  consumer accepts result
- result_o  out  64  result
- busy_o  out  1  state != IDLE

## Operation
- States and transitions:
  - IDLE -> PASS0 on valid_i & ready_o.
  - PASS0 -> PASS1 (two-pass ops) or DONE (single-pass ops).
  - PASS1 -> DONE.
  - DONE -> IDLE on ready_i.
- op_a, op_b, acc, op and signedness are latched on acceptance. Later changes on the inputs have no effect.
- Operand use per pass:
  - Every pass: mul_a_o = latched a, mul_a_signed_o = signed_a.
  - PASS0, two-pass ops: mul_b_o = b[15:0], mul_b_signed_o = 0.
  - PASS0, single-pass ops: mul_b_o = b[15:0], mul_b_signed_o = signed_b.
  - PASS1: mul_b_o = b[31:16], mul_b_signed_o = signed_b.
- Each pass:
  - First cycle: mul_valid_o = 1.
  - Operands held stable for the whole pass.
  - A pass counter runs 0..MulLatency; mul_result_i is captured when the counter equals MulLatency.
- Partial-product extension: the 48-bit product is extended to 64 bits. Sign-extend if either array operand is signed, otherwise zero-extend.
- Results (all arithmetic modulo 2^64):
  - SINGLE: result = P0.
  - MAC: result = P0 + ext(acc_i). acc_i is sign-extended if signed_a | signed_b, otherwise zero-extended.
  - FULL: result = P0 + (P1 << 16).
  - HIGH_RND: R = (P0 + (P1 << 16) + 2^31) >> 32, arithmetic shift if signed_a | signed_b. result_o = R[31:0] extended per the same signedness to 64 bits.
- DONE:
  - valid_o = 1.
  - result_o is held stable until ready_i.
  - valid_i is ignored (ready_o = 0).
- flush_i in any non-IDLE state:
  - Next state is IDLE.
  - Accumulator is cleared and valid_o is 0 from the next cycle.
  - No result is produced.
  - A mul_result_i already in flight is ignored.
- flush_i in IDLE has no effect. flush_i takes priority over ready_i in DONE.

## Timing
- Reset (asynchronous) forces:
  - state = IDLE, so ready_o = 1.
  - valid_o = 0, busy_o = 0, mul_valid_o = 0.
  - result_o = 0, mul_a_o = 0, mul_b_o = 0, both mul signedness outputs = 0.
  - Accumulator = 0, pass counter = 0.
- Reset in the middle of an operation abandons it. The first accept after reset starts a clean operation.
- Cycle numbering: acceptance edge is cycle 0.
  - PASS0 occupies cycles 1..1+MulLatency.
  - Single-pass ops: valid_o first high in cycle 2+MulLatency.
  - Two-pass ops: valid_o first high in cycle 3+2·MulLatency.
- Minimum initiation interval: result latency + 1. The DONE->IDLE edge is needed before the next accept.
- mul_valid_o is high for exactly one cycle per pass: one strobe for single-pass ops, two for two-pass ops.

## Test plan
- SINGLE, signed_a = signed_b = 1, a = 0xFFFF_FFFE, b = 0x0000_0003, MulLatency = 0:
  - result_o = 0xFFFF_FFFF_FFFF_FFFA.
  - valid_o high in cycle 2.
  - One mul_valid_o pulse.
- FULL, a = b = 0xFFFF_FFFF, MulLatency = 2:
  - Unsigned gives 0xFFFF_FFFE_0000_0001; signed gives 0x0000_0000_0000_0001.
  - valid_o high in cycle 7.
  - Exactly two mul_valid_o pulses.
- HIGH_RND, signed, a = 0x4000_0000, b = 0x0000_0003:
  - result_o = 0x0000_0000_0000_0001 (0xC000_0000 + 2^31, shifted right by 32).
- MAC, signed, a = 0x0001_0000, b = 0x0002, acc = 0xFFFF_FFFF:
  - result_o = 0x0000_0000_0001_FFFF.
- Backpressure: hold ready_i = 0 for 5 cycles in DONE while pulsing valid_i:
  - result_o stable, valid_o = 1, ready_o = 0.
  - No new accept occurs.
  - After ready_i, the next accept happens only from IDLE.
- Abort cases:
  - Assert flush_i in PASS1: IDLE next cycle, valid_o never rises, and the following op returns a correct result.
  - Repeat with rst_ni low mid-PASS0: all outputs go to their reset values immediately.
